rdata_return_fifo: RTL

Read-data return path of the DDR memory controller: the read-side counterpart of the write-data FIFO. It captures read bursts beat-by-beat from the PHY and deserializes each burst into one full-width word. Each word is paired, in order, with the ID of the read command that produced it and buffered until the host accepts it. A credit count tells the command scheduler when to stop issuing reads, so returned data can never overflow the buffer.

---
 rtl/rdata_return_fifo_if.sv | 33 +++
 rtl/rdata_return_fifo.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rdata_return_fifo_if.sv
// Read-return bus bundle: scheduler issue, PHY read beats and the host-facing word stream.
// The slave modport is the return FIFO; the master modport is the surrounding controller.
interface rdata_return_fifo_if #(
    parameter int unsigned DQ_WIDTH  = 16,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ID_WIDTH  = 4
);
    localparam int unsigned W = DQ_WIDTH * BURST_LEN;
    localparam int unsigned C = $clog2(DEPTH) + 1;

    logic                cmd_issue;
    logic [ID_WIDTH-1:0] cmd_id;
    logic                dq_valid;
    logic [DQ_WIDTH-1:0] dq_data;
    logic                rd_valid;
    logic [W-1:0]        rd_data;
    logic [ID_WIDTH-1:0] rd_id;
    logic                rd_ready;
    logic                rd_stall;
    logic [C-1:0]        credits;
    logic                err;

    modport master (
        output cmd_issue, cmd_id, dq_valid, dq_data, rd_ready,
        input  rd_valid, rd_data, rd_id, rd_stall, credits, err
    );

    modport slave (
        input  cmd_issue, cmd_id, dq_valid, dq_data, rd_ready,
        output rd_valid, rd_data, rd_id, rd_stall, credits, err
    );
endinterface

// File: rtl/rdata_return_fifo.sv
// DDR read-data return path: deserializes PHY bursts into words, pairs each with its
// command ID in issue order, and buffers them FWFT behind a credit-based stall.
module rdata_return_fifo #(
    parameter int unsigned DQ_WIDTH  = 16,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned STALL_TH  = 2
) (
    input logic               clk,
    input logic               rst_n,
    rdata_return_fifo_if.slave bus
);
    localparam int unsigned W  = DQ_WIDTH * BURST_LEN;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned C  = PW + 1;
    localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    // Tag queue: IDs of reads issued but not yet returned
    logic [ID_WIDTH-1:0] r_tag_mem [DEPTH];
    logic [PW-1:0]       r_tag_wptr;
    logic [PW-1:0]       r_tag_rptr;
    logic [C-1:0]        r_inflight;

    // Data queue: assembled words and their paired IDs
    logic [W-1:0]        r_data_mem [DEPTH];
    logic [ID_WIDTH-1:0] r_id_mem   [DEPTH];
    logic [PW-1:0]       r_data_wptr;
    logic [PW-1:0]       r_data_rptr;
    logic [C-1:0]        r_data_count;

    logic [BW-1:0]       r_beat_cnt;
    logic [W-1:0]        r_word;
    logic                r_err;

    logic [C-1:0]        w_credits;
    logic                w_issue_ok;
    logic                w_drop;
    logic                w_spurious;
    logic                w_beat;
    logic                w_complete;
    logic                w_rd_valid;
    logic                w_pop;
    logic [W-1:0]        w_word_next;
    logic [C-1:0]        w_inflight_d;
    logic [C-1:0]        w_data_count_d;

    assign w_credits  = C'(DEPTH) - r_data_count - r_inflight;
    assign w_issue_ok = bus.cmd_issue && (w_credits != '0);
    assign w_drop     = bus.cmd_issue && (w_credits == '0);
    // A beat can only be orphaned at a burst boundary; mid-burst implies a tag is in flight
    assign w_spurious = bus.dq_valid && (r_inflight == '0) && (r_beat_cnt == '0);
    assign w_beat     = bus.dq_valid && !w_spurious;
    assign w_complete = w_beat && (r_beat_cnt == BW'(BURST_LEN - 1));
    assign w_rd_valid = (r_data_count != '0);
    assign w_pop      = w_rd_valid && bus.rd_ready;

    always_comb begin
        w_word_next = r_word;
        for (int k = 0; k < int'(BURST_LEN); k++) begin
            if (r_beat_cnt == BW'(k)) begin
                w_word_next[k*DQ_WIDTH +: DQ_WIDTH] = bus.dq_data;
            end
        end
    end

    always_comb begin
        w_inflight_d = r_inflight;
        if (w_issue_ok && !w_complete) begin
            w_inflight_d = r_inflight + C'(1);
        end else if (!w_issue_ok && w_complete) begin
            w_inflight_d = r_inflight - C'(1);
        end
    end

    always_comb begin
        w_data_count_d = r_data_count;
        if (w_complete && !w_pop) begin
            w_data_count_d = r_data_count + C'(1);
        end else if (!w_complete && w_pop) begin
            w_data_count_d = r_data_count - C'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_wptr   <= '0;
            r_tag_rptr   <= '0;
            r_inflight   <= '0;
            r_data_wptr  <= '0;
            r_data_rptr  <= '0;
            r_data_count <= '0;
            r_beat_cnt   <= '0;
            r_word       <= '0;
            r_err        <= 1'b0;
        end else begin
            r_inflight   <= w_inflight_d;
            r_data_count <= w_data_count_d;
            if (w_issue_ok) begin
                r_tag_wptr <= r_tag_wptr + PW'(1);
            end
            if (w_complete) begin
                r_tag_rptr  <= r_tag_rptr + PW'(1);
                r_data_wptr <= r_data_wptr + PW'(1);
                r_beat_cnt  <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + BW'(1);
            end
            if (w_beat) begin
                r_word <= w_word_next;
            end
            if (w_pop) begin
                r_data_rptr <= r_data_rptr + PW'(1);
            end
            if (w_drop || w_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

    // Storage arrays carry no reset; pointers alone define validity
    always_ff @(posedge clk) begin
        if (w_issue_ok) begin
            r_tag_mem[r_tag_wptr] <= bus.cmd_id;
        end
        if (w_complete) begin
            r_data_mem[r_data_wptr] <= w_word_next;
            r_id_mem[r_data_wptr]   <= r_tag_mem[r_tag_rptr];
        end
    end

    assign bus.rd_valid = w_rd_valid;
    assign bus.rd_data  = w_rd_valid ? r_data_mem[r_data_rptr] : '0;
    assign bus.rd_id    = w_rd_valid ? r_id_mem[r_data_rptr] : '0;
    assign bus.credits  = w_credits;
    assign bus.rd_stall = (w_credits < C'(STALL_TH));
    assign bus.err      = r_err;
endmodule
